// File: rtl/ds1302_pkg.sv
// ds1302_pkg: shared FSM encoding, request codes and slot-count width for the DS1302 access engine.
package ds1302_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, CMD, WDAT, RDAT, HOLD, RECOV, DONE} state_t;
    localparam logic [1:0] START_WR = 2'b10;
    localparam logic [1:0] START_RD = 2'b01;
    localparam int SLOT_W = 4;
endpackage

// File: rtl/ds1302_bit_timer.sv
// ds1302_bit_timer: SCLK phase generator; slot index counts 16 bit slots, strobes fire on the last cycle of a phase.
module ds1302_bit_timer
    import ds1302_pkg::*;
#(
    parameter int HALF_CYC = 25
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              en,
    output logic              sclk,
    output logic              fall,
    output logic              sample,
    output logic [SLOT_W-1:0] slot
);
    localparam int CW = $clog2(HALF_CYC);
    logic [CW-1:0] cnt;
    logic last;
    assign last   = cnt == CW'(HALF_CYC - 1);
    assign fall   = en & last & sclk;
    assign sample = en & last & ~sclk;
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt  <= '0;
            sclk <= 1'b0;
            slot <= '0;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b0;
            slot <= '0;
        end else if (last) begin
            cnt  <= '0;
            sclk <= ~sclk;
            slot <= sclk ? slot + SLOT_W'(1) : slot;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/ds1302_access.sv
// ds1302_access: DS1302 3-wire engine running one command+data byte transfer per request.
// Define DS1302_SIO_SYNC_EN to pass RTC_DATA through a 2-flop synchronizer before sampling.
module ds1302_access
    import ds1302_pkg::*;
#(
    parameter int HALF_CYC = 25,
    parameter int CE_SETUP = 50
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [1:0] Start_Sig,
    input  logic [7:0] Words_Addr,
    input  logic [7:0] Write_Data,
    output logic       Done_Sig,
    output logic [7:0] Read_Data,
    output logic       RTC_NRST,
    output logic       RTC_SCLK,
    inout  wire        RTC_DATA
);
    state_t state, state_n;
    logic [15:0] dly, tx;
    logic [7:0] rx;
    logic [SLOT_W-1:0] slot;
    logic armed, rd, sio_o, sio_oe, sio_in, fall, sample, tmr_en, accept;

    assign tmr_en   = state inside {CMD, WDAT, RDAT};
    assign accept   = state == IDLE && armed && (Start_Sig == START_WR || Start_Sig == START_RD);
    assign RTC_DATA = sio_oe ? sio_o : 1'bz;

    ds1302_bit_timer #(.HALF_CYC(HALF_CYC)) u_timer (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .en    (tmr_en),
        .sclk  (RTC_SCLK),
        .fall  (fall),
        .sample(sample),
        .slot  (slot)
    );

`ifdef DS1302_SIO_SYNC_EN
    logic sio_s1, sio_s2;
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sio_s1 <= 1'b0;
            sio_s2 <= 1'b0;
        end else begin
            sio_s1 <= RTC_DATA;
            sio_s2 <= sio_s1;
        end
    end
    assign sio_in = sio_s2;
`else
    assign sio_in = RTC_DATA;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:       state_n = accept ? SETUP : IDLE;
            SETUP:      state_n = dly == 16'(CE_SETUP - 1) ? CMD : SETUP;
            CMD:        state_n = fall && slot == SLOT_W'(7) ? (rd ? RDAT : WDAT) : CMD;
            WDAT, RDAT: state_n = fall && slot == SLOT_W'(15) ? HOLD : state;
            HOLD:       state_n = dly == 16'(HALF_CYC - 1) ? RECOV : HOLD;
            RECOV:      state_n = dly == 16'(CE_SETUP - 1) ? DONE : RECOV;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            dly       <= '0;
            armed     <= 1'b1;
            rd        <= 1'b0;
            tx        <= '0;
            rx        <= '0;
            sio_o     <= 1'b0;
            sio_oe    <= 1'b0;
            RTC_NRST  <= 1'b0;
            Done_Sig  <= 1'b0;
            Read_Data <= 8'h00;
        end else begin
            state    <= state_n;
            dly      <= state_n != state ? 16'd0 : dly + 16'd1;
            armed    <= (state == IDLE && Start_Sig == 2'b00) ? 1'b1 : (accept ? 1'b0 : armed);
            sio_oe   <= state_n inside {CMD, WDAT};
            RTC_NRST <= state_n inside {SETUP, CMD, WDAT, RDAT, HOLD};
            Done_Sig <= state_n == DONE;
            if (accept) begin
                rd <= Start_Sig == START_RD;
                tx <= {Write_Data, Words_Addr};
            end else if ((state == SETUP && state_n == CMD) || fall) begin
                sio_o <= tx[0];
                tx    <= {1'b0, tx[15:1]};
            end
            if (state == RDAT && sample)
                rx <= {sio_in, rx[7:1]};
            if (state_n == DONE && rd)
                Read_Data <= rx;
        end
    end
endmodule

// File: tb/tb_ds1302_access.sv
// tb_ds1302_access: directed vectors against two engines (default timing and HALF_CYC=4) with a behavioural RTC.
module tb_ds1302_access;
    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] start[2];
    logic [7:0] addr[2], wdat[2], rdata[2], rbyte[2];
    logic done[2], ce[2], sclk[2], sio_v[2], ps[2];
    logic [1:0] m_oe, m_bit;
    logic [4:0] nf[2], nr[2];
    logic [15:0] cap[2];
    wire sio0, sio1;
    int tests = 0, fails = 0, lat, bad;

    typedef struct {
        int d;
        logic [1:0] st;
        logic [7:0] a, w, r, exp_rd;
        logic [15:0] bits;
        int lat;
    } vec_t;
    vec_t v[7];

    always #5 clk = ~clk;

    assign sio0 = m_oe[0] ? m_bit[0] : 1'bz;
    assign sio1 = m_oe[1] ? m_bit[1] : 1'bz;
    pullup (sio0);
    pullup (sio1);
    assign sio_v[0] = sio0;
    assign sio_v[1] = sio1;

    ds1302_access dut0 (
        .CLK(clk), .RSTn(rst_n), .Start_Sig(start[0]), .Words_Addr(addr[0]), .Write_Data(wdat[0]),
        .Done_Sig(done[0]), .Read_Data(rdata[0]), .RTC_NRST(ce[0]), .RTC_SCLK(sclk[0]), .RTC_DATA(sio0)
    );
    ds1302_access #(.HALF_CYC(4), .CE_SETUP(8)) dut1 (
        .CLK(clk), .RSTn(rst_n), .Start_Sig(start[1]), .Words_Addr(addr[1]), .Write_Data(wdat[1]),
        .Done_Sig(done[1]), .Read_Data(rdata[1]), .RTC_NRST(ce[1]), .RTC_SCLK(sclk[1]), .RTC_DATA(sio1)
    );

    // RTC model: captures SIO on SCLK rises, answers reads after the 8th fall.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!ce[i]) begin
                nf[i] <= '0;
                nr[i] <= '0;
                m_oe[i] <= 1'b0;
            end else begin
                if (sclk[i] && !ps[i]) begin
                    cap[i][nr[i][3:0]] <= sio_v[i];
                    nr[i] <= nr[i] + 5'd1;
                end
                if (!sclk[i] && ps[i]) begin
                    nf[i] <= nf[i] + 5'd1;
                    m_oe[i] <= cap[i][0] && nf[i] >= 5'd7 && nf[i] <= 5'd14;
                    m_bit[i] <= rbyte[i][3'(nf[i] - 5'd7)];
                end
            end
            ps[i] <= sclk[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic xfer(input int d, input logic [1:0] st, input logic [7:0] a, input logic [7:0] w,
                        input logic [7:0] r, input bit rel, output int n);
        rbyte[d] = r;
        addr[d]  = a;
        wdat[d]  = w;
        start[d] = st;
        n = 0;
        while (!done[d] && n < 4000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("done_pulse", done[d], 0);
        check("idle_ce", ce[d], 0);
        check("idle_sclk", sclk[d], 0);
        check("idle_sio", sio_v[d], 1);
        if (rel) start[d] = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        v[0] = '{0, 2'b10, 8'h80, 8'h45, 8'h00, 8'h00, 16'h4580, 926};
        v[1] = '{0, 2'b01, 8'h81, 8'h00, 8'h59, 8'h59, 16'h5981, 926};
        v[2] = '{0, 2'b10, 8'h8E, 8'h00, 8'h00, 8'h59, 16'h008E, 926};
        v[3] = '{0, 2'b01, 8'hC1, 8'h00, 8'hA6, 8'hA6, 16'hA6C1, 926};
        v[4] = '{0, 2'b10, 8'h8C, 8'hFF, 8'h00, 8'hA6, 16'hFF8C, 926};
        v[5] = '{1, 2'b01, 8'h81, 8'h00, 8'h59, 8'h59, 16'h5981, 149};
        v[6] = '{1, 2'b01, 8'h83, 8'h00, 8'h3C, 8'h3C, 16'h3C83, 149};
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start[i] = 2'b00; addr[i] = 8'h00; wdat[i] = 8'h00; rbyte[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check("rst_ce", ce[0], 0);
        check("rst_sclk", sclk[0], 0);
        check("rst_done", done[0], 0);
        check("rst_rdata", rdata[0], 8'h00);
        check("rst_sio", sio_v[0], 1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            xfer(v[k].d, v[k].st, v[k].a, v[k].w, v[k].r, 1'b1, lat);
            check($sformatf("v%0d_latency", k), lat, v[k].lat);
            check($sformatf("v%0d_rdata", k), rdata[v[k].d], v[k].exp_rd);
            check($sformatf("v%0d_sio_bits", k), cap[v[k].d], v[k].bits);
        end

        start[0] = 2'b11;
        bad = 0;
        repeat (2000) begin
            @(negedge clk);
            if (ce[0] || sclk[0] || done[0]) bad++;
        end
        check("t3_start11_idle", bad, 0);
        start[0] = 2'b00;
        @(negedge clk);
        xfer(0, 2'b01, 8'h81, 8'h00, 8'h5A, 1'b1, lat);
        check("t3_latency", lat, 926);
        check("t3_rdata", rdata[0], 8'h5A);

        xfer(0, 2'b10, 8'h80, 8'h45, 8'h00, 1'b0, lat);
        check("t4_first_latency", lat, 926);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (ce[0]) bad++;
        end
        check("t4_no_rearm", bad, 0);
        start[0] = 2'b00;
        @(negedge clk);
        xfer(0, 2'b10, 8'h80, 8'h45, 8'h00, 1'b1, lat);
        check("t4_rearm_latency", lat, 926);

        rbyte[0] = 8'h00; addr[0] = 8'h80; wdat[0] = 8'h45; start[0] = 2'b10;
        repeat (400) @(negedge clk);
        check("t5_pre_sclk", sclk[0], 1);
        check("t5_pre_sio", sio_v[0], 0);
        rst_n = 1'b0;
        #1;
        check("t5_ce", ce[0], 0);
        check("t5_sclk", sclk[0], 0);
        check("t5_sio", sio_v[0], 1);
        check("t5_done", done[0], 0);
        start[0] = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xfer(0, 2'b01, 8'h81, 8'h00, 8'h59, 1'b1, lat);
        check("t5_latency", lat, 926);
        check("t5_rdata", rdata[0], 8'h59);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
